coax_fifo_tx: RTL and testbench
===============================

// Module: coax_fifo_tx
// PURPOSE
//  3270 coax serialiser with a parametrised transmit FIFO. It replaces the fixed
//  two-word transmitter and sits between the host command path and the line driver.
//  It buffers up to DEPTH words, then sends them as one back-to-back frame with a
//  start sequence, sync, data, parity and end sequence.
//  It adds a valid/ready write handshake, a level report, a sticky overflow flag and a
//  selectable parity sense.
// PARAMETERS
//  CLOCKS_PER_BIT  8   clocks per bit cell; even, >=4
//  DATA_WIDTH      10  bits per word, sent MSB first
//  DEPTH           8   FIFO words; power of 2, >=2
//  PARITY_ODD      0   0: even parity over {sync,data}; 1: odd parity
// PORTS
//  clk             in   1    system clock
//  reset_n         in   1    asynchronous, active-low reset
//  data            in   DW   word to queue
//  valid           in   1    write strobe; accepted when valid && ready
//  ready           out  1    combinational !full
//  full            out  1    level == DEPTH
//  empty           out  1    level == 0
//  level           out  AW+1 words in FIFO, where AW = $clog2(DEPTH)
//  overflow        out  1    sticky; set by valid && !ready
//  clear_overflow  in   1    1-cycle pulse that clears overflow
//  active          out  1    registered; high while a frame is on the line
//  tx              out  1    registered line output
// BEHAVIOUR
//  - Reset (async assert, sync release): tx=0, active=0, overflow=0, level=0, FSM=IDLE.
//    Asserting reset mid-frame truncates the frame immediately and flushes the FIFO.
//  - Cell encoding for bit b: first half (timer < CPB/2) drives ~b, second half drives b.
//    The bit timer counts 0..CPB-1 and restarts on every cell.
//  - FSM states: IDLE -> START_HALF -> LINE_QUIESCE(5 cells of '1') -> VIOL_LOW (1 cell low)
//    -> VIOL_ONE ('1') -> VIOL_HIGH (1 cell high) -> SYNC ('1') -> DATA (DW cells)
//    -> PARITY -> END_ZERO (cell '0': high then low) -> END_HIGH (2 cells high) -> IDLE (tx=0).
//  - START_HALF drives tx high for CPB/2 clocks.
//  - Latency: a write accepted on edge N into an idle block gives active=1 and tx=1 at N+2.
//  - Word pop: the FIFO head loads the shift register on the last clock before SYNC.
//    At PARITY's last clock: if the FIFO is non-empty, go to SYNC (no gap);
//    otherwise go to END_ZERO.
//  - Parity bit = ^{1'b1,word} ^ PARITY_ODD.
//  - A write and a pop in the same cycle leave level unchanged.
//  - A write while full is dropped, sets overflow and leaves the FIFO untouched.
//  - If clear_overflow and a new overflow occur in the same cycle, overflow stays set.
//  - Writes during END_* are queued for the next frame.
//    The FSM returns to IDLE first, then restarts from START_HALF.
//  - active is low in IDLE only. It drops together with the final tx=0.
// CONFIGURATION
//  COAX_TX_PARITY_INJECT_EN defined:
//  - Adds input inject_parity_err (1 bit).
//  - A pulse arms a one-shot flag, which inverts the parity of the next word to enter
//    PARITY and then self-clears.
//  - A pulse during PARITY applies to the following word.
//  Undefined: the port is absent and parity is always correct.
// STRUCTURE
//  - Package coax_pkg holds the tx_state_t enum, the quiesce/violation cell counts and the
//    parity helper function.
//  - Sub-module coax_tx_fifo: DEPTH x DW synchronous FIFO (wr, rd, level, full, empty),
//    using async active-low reset.
//  - The FSM, bit timer and shift register live in this module.
// TESTING
//  T1: CPB=8, PARITY_ODD=0, write 10'h155 -> active at +2.
//      Expect a 68-clock start sequence, then sync 01, data cells MSB first
//      (0101010101 as ~b/b pairs), parity 0, end sequence, then active=0.
//      Frame length = 68+96+24 clocks.
//  T2: write 10'h003, then 10'h2AA 5 cycles later.
//      Expect a single frame: parity 1, then parity 0; the second SYNC starts on the
//      clock right after the first PARITY cell; one end sequence.
//  T3: with tx stalled in start, write DEPTH+1 words.
//      Expect full=1, ready=0, 9th word dropped, overflow=1.
//      All 8 words are sent in order; clear_overflow -> overflow=0.
//  T4: reset_n low during DATA bit 4.
//      Expect tx=0, active=0, level=0 with no clock edge.
//      After release, a new write gives a normal frame.
//  T5: PARITY_ODD=1, write 10'h155 -> parity cell carries 1.
//  T6 (COAX_TX_PARITY_INJECT_EN): pulse inject, write 10'h155, 10'h155.
//      Expect parity 1 on the first word and 0 on the second.

Source files
------------

// File: rtl/coax_pkg.sv
// Shared state encoding, cell counts and parity helper for the 3270 coax transmitter.
package coax_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START_HALF,
    ST_QUIESCE,
    ST_VIOL_LOW,
    ST_VIOL_ONE,
    ST_VIOL_HIGH,
    ST_SYNC,
    ST_DATA,
    ST_PARITY,
    ST_END_ZERO,
    ST_END_HIGH
  } tx_state_t;

  localparam int QUIESCE_CELLS  = 5;
  localparam int VIOL_CELLS     = 1;
  localparam int END_HIGH_CELLS = 2;

  // The sync bit is counted in the parity; zero-extension of narrow words is harmless.
  function automatic logic coax_parity(input logic [31:0] word, input logic odd);
    return (^{1'b1, word}) ^ odd;
  endfunction

endpackage

// File: rtl/coax_tx_fifo.sv
// DEPTH x DW show-ahead FIFO; rd_data is the head word, updated the clock after a pop.
// Writes while full and reads while empty are ignored; simultaneous write and read keep level.
module coax_tx_fifo #(
  parameter int DW    = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr,
  input  logic [DW-1:0]            wr_data,
  input  logic                     rd,
  output logic [DW-1:0]            rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = DEPTH[AW:0];

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign do_wr   = wr && !full;
  assign do_rd   = rd && !empty;
  assign full    = (level == LVL_FULL);
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd)      level <= level + 1'b1;
      else if (!do_wr && do_rd) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/coax_fifo_tx.sv
// 3270 coax serialiser with a DEPTH-word transmit FIFO; COAX_TX_PARITY_INJECT_EN adds parity error injection.
// Write-to-line latency 2 clocks; ready = !full, writes while full are dropped and flagged in sticky overflow.
module coax_fifo_tx
  import coax_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 8,
  parameter int DATA_WIDTH     = 10,
  parameter int DEPTH          = 8,
  parameter int PARITY_ODD     = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DATA_WIDTH-1:0]    data,
  input  logic                     valid,
  output logic                     ready,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clear_overflow,
`ifdef COAX_TX_PARITY_INJECT_EN
  input  logic                     inject_parity_err,
`endif
  output logic                     active,
  output logic                     tx
);

  localparam int DW = DATA_WIDTH;
  localparam int TW = $clog2(CLOCKS_PER_BIT);
  localparam logic [TW-1:0] T_LAST      = TW'(CLOCKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF      = TW'(CLOCKS_PER_BIT / 2);
  localparam logic [TW-1:0] T_HALF_LAST = TW'(CLOCKS_PER_BIT / 2 - 1);

  tx_state_t     state;
  tx_state_t     next_state;
  logic [TW-1:0] timer;
  logic [7:0]    cell_cnt;
  logic [DW-1:0] sreg;
  logic [DW-1:0] head;
  logic          par_bit;
  logic          inj_armed;
  logic          inj_pulse;
  logic          inj_take;
  logic          cell_done;
  logic          state_done;
  logic          pop;
  logic          wr_ok;
  logic          line_nxt;
  logic          cell_bit;
  logic          coded;
  logic          raw;
  int            state_cells;

`ifdef COAX_TX_PARITY_INJECT_EN
  assign inj_pulse = inject_parity_err;
`else
  assign inj_pulse = 1'b0;
`endif

  assign ready = !full;
  assign wr_ok = valid && ready;

  coax_tx_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr      (wr_ok),
    .wr_data (data),
    .rd      (pop),
    .rd_data (head),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  // START_HALF is a half cell; every other state runs in whole cells.
  assign cell_done = (state == ST_START_HALF) ? (timer == T_HALF_LAST) : (timer == T_LAST);

  always_comb begin
    state_cells = 1;
    case (state)
      ST_QUIESCE:               state_cells = QUIESCE_CELLS;
      ST_VIOL_LOW, ST_VIOL_HIGH: state_cells = VIOL_CELLS;
      ST_DATA:                  state_cells = DW;
      ST_END_HIGH:              state_cells = END_HIGH_CELLS;
      default:                  state_cells = 1;
    endcase
  end

  assign state_done = (state != ST_IDLE) && cell_done && (cell_cnt == 8'(state_cells - 1));
  assign pop        = state_done && ((state == ST_VIOL_HIGH) || ((state == ST_PARITY) && !empty));
  assign inj_take   = state_done && (state == ST_DATA) && inj_armed;

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:       next_state = empty ? ST_IDLE : ST_START_HALF;
      ST_START_HALF: next_state = ST_QUIESCE;
      ST_QUIESCE:    next_state = ST_VIOL_LOW;
      ST_VIOL_LOW:   next_state = ST_VIOL_ONE;
      ST_VIOL_ONE:   next_state = ST_VIOL_HIGH;
      ST_VIOL_HIGH:  next_state = ST_SYNC;
      ST_SYNC:       next_state = ST_DATA;
      ST_DATA:       next_state = ST_PARITY;
      ST_PARITY:     next_state = empty ? ST_END_ZERO : ST_SYNC;
      ST_END_ZERO:   next_state = ST_END_HIGH;
      ST_END_HIGH:   next_state = ST_IDLE;
      default:       next_state = ST_IDLE;
    endcase
  end

  // Coded cells send ~b for the first half and b for the second; the rest are flat levels.
  always_comb begin
    coded    = 1'b1;
    raw      = 1'b0;
    cell_bit = 1'b1;
    case (state)
      ST_IDLE:                  begin coded = 1'b0; raw = 1'b0; end
      ST_START_HALF:            begin coded = 1'b0; raw = 1'b1; end
      ST_VIOL_LOW:              begin coded = 1'b0; raw = 1'b0; end
      ST_VIOL_HIGH, ST_END_HIGH: begin coded = 1'b0; raw = 1'b1; end
      ST_DATA:                  cell_bit = sreg[DW-1];
      ST_PARITY:                cell_bit = par_bit;
      ST_END_ZERO:              cell_bit = 1'b0;
      default:                  cell_bit = 1'b1;
    endcase
    line_nxt = coded ? ((timer < T_HALF) ? ~cell_bit : cell_bit) : raw;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      timer     <= '0;
      cell_cnt  <= '0;
      sreg      <= '0;
      par_bit   <= 1'b0;
      inj_armed <= 1'b0;
      tx        <= 1'b0;
      active    <= 1'b0;
    end else begin
      tx        <= line_nxt;
      active    <= (state != ST_IDLE);
      inj_armed <= (inj_armed && !inj_take) || inj_pulse;

      if ((state == ST_IDLE) || cell_done) timer <= '0;
      else                                 timer <= timer + 1'b1;

      if (state_done)     cell_cnt <= '0;
      else if (cell_done) cell_cnt <= cell_cnt + 1'b1;

      if (pop) begin
        sreg    <= head;
        par_bit <= coax_parity(32'(head), PARITY_ODD != 0);
      end else begin
        if ((state == ST_DATA) && cell_done) sreg <= {sreg[DW-2:0], 1'b0};
        if (inj_take) par_bit <= !par_bit;
      end

      if ((state == ST_IDLE) || state_done) state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                overflow <= 1'b0;
    else if (valid && !ready)    overflow <= 1'b1;
    else if (clear_overflow)     overflow <= 1'b0;
  end

endmodule

// File: tb/tb_coax_fifo_tx.sv
// Scoreboard bench: an even-parity and an odd-parity instance share stimulus; frames are decoded off tx.
module tb_coax_fifo_tx;

  localparam logic [127:0] START_PAT = 128'hF0F0F0F0F0F000FFF;
  localparam logic [127:0] END_PAT   = 128'hF0FFFF;

  logic       clk;
  logic       reset_n;
  logic [9:0] data;
  logic       valid;
  logic       clear_overflow;
  logic       ready_e, full_e, empty_e, ovf_e, act_e, tx_e;
  logic       ready_o, full_o, empty_o, ovf_o, act_o, tx_o;
  logic [3:0] level_e, level_o;
`ifdef COAX_TX_PARITY_INJECT_EN
  logic       inject;
`endif

  int n_cmp;
  int n_fail;
  int frames_done;
  int flen;
  logic [1:0]  fbuf [0:1023];
  logic [10:0] exp_q [$];
  int          frame_q [$];

  logic [9:0] t3w [0:7] = '{10'h3FF, 10'h000, 10'h155, 10'h2AA, 10'h003, 10'h001, 10'h080, 10'h3F0};
  logic       t3p [0:7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  coax_fifo_tx #(.CLOCKS_PER_BIT(8), .DATA_WIDTH(10), .DEPTH(8), .PARITY_ODD(0)) dut (
    .clk(clk), .reset_n(reset_n), .data(data), .valid(valid), .ready(ready_e),
    .full(full_e), .empty(empty_e), .level(level_e), .overflow(ovf_e),
    .clear_overflow(clear_overflow),
`ifdef COAX_TX_PARITY_INJECT_EN
    .inject_parity_err(inject),
`endif
    .active(act_e), .tx(tx_e)
  );

  coax_fifo_tx #(.CLOCKS_PER_BIT(8), .DATA_WIDTH(10), .DEPTH(8), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .reset_n(reset_n), .data(data), .valid(valid), .ready(ready_o),
    .full(full_o), .empty(empty_o), .level(level_o), .overflow(ovf_o),
    .clear_overflow(clear_overflow),
`ifdef COAX_TX_PARITY_INJECT_EN
    .inject_parity_err(inject),
`endif
    .active(act_o), .tx(tx_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] cell8(input int lane, input int pos);
    logic [7:0] r = '0;
    for (int j = 0; j < 8; j++) r = {r[6:0], fbuf[pos + j][lane]};
    return r;
  endfunction

  task automatic push_w(input logic [9:0] w, input logic p);
    exp_q.push_back({p, w});
  endtask

  task automatic process_frame();
    int          n;
    int          base;
    int          bad;
    logic [127:0] sv;
    logic [7:0]  c;
    logic [9:0]  w;
    logic [10:0] ents [0:7];
    string       ln;
    n = (frame_q.size() > 0) ? frame_q.pop_front() : 0;
    chk("frame_len", 128'(flen), 128'(92 + 96 * n));
    for (int k = 0; k < n && k < 8; k++) begin
      chk("exp_avail", 128'(exp_q.size() > 0), 128'(1));
      ents[k] = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h0;
    end
    for (int lane = 0; lane < 2; lane++) begin
      ln = (lane == 1) ? "_odd" : "_even";
      if (flen >= 68) begin
        sv = '0;
        for (int i = 0; i < 68; i++) sv = {sv[126:0], fbuf[i][lane]};
        chk({"start", ln}, sv, START_PAT);
      end
      for (int k = 0; k < n && k < 8; k++) begin
        base = 68 + 96 * k;
        if (base + 96 <= flen) begin
          chk({"sync", ln}, 128'(cell8(lane, base)), 128'h0F);
          w = '0;
          bad = 0;
          for (int i = 0; i < 10; i++) begin
            c = cell8(lane, base + 8 + 8 * i);
            if (c != 8'h0F && c != 8'hF0) bad++;
            w = {w[8:0], c[0]};
          end
          c = cell8(lane, base + 88);
          if (c != 8'h0F && c != 8'hF0) bad++;
          chk({"cell_code", ln}, 128'(bad), 128'(0));
          chk({"data", ln}, 128'(w), 128'(ents[k][9:0]));
          chk({"parity", ln}, 128'(c[0]), 128'(ents[k][10] ^ (lane == 1)));
        end
      end
      base = 68 + 96 * n;
      if (base + 24 <= flen) begin
        sv = '0;
        for (int i = 0; i < 24; i++) sv = {sv[126:0], fbuf[base + i][lane]};
        chk({"end", ln}, sv, END_PAT);
      end
    end
    frames_done++;
  endtask

  // Monitor: capture both lines while active, decode when the frame ends.
  always @(negedge clk) begin
    if (!reset_n) begin
      flen = 0;
    end else if (act_e) begin
      if (flen < 1024) begin
        fbuf[flen] = {tx_o, tx_e};
        flen++;
      end
    end else if (flen > 0) begin
      process_frame();
      flen = 0;
    end
  end

  task automatic wr(input logic [9:0] w);
    @(posedge clk); #1;
    data  = w;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int c = 0;
    while (frames_done < target && c < budget) begin
      @(posedge clk);
      c++;
    end
    chk("frame_wait", 128'(frames_done >= target), 128'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    int nfr;
    n_cmp = 0; n_fail = 0; frames_done = 0; flen = 0;
    reset_n = 1'b0; valid = 1'b0; data = '0; clear_overflow = 1'b0;
`ifdef COAX_TX_PARITY_INJECT_EN
    inject = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 128'(tx_e), 128'(0));
    chk("rst_active", 128'(act_e), 128'(0));
    chk("rst_level", 128'(level_e), 128'(0));
    chk("rst_overflow", 128'(ovf_e), 128'(0));
    chk("rst_empty", 128'(empty_e), 128'(1));
    chk("rst_ready", 128'(ready_e), 128'(1));
    reset_n = 1'b1;

    // T1 / T5: single word, latency 2
    push_w(10'h155, 1'b0);
    frame_q.push_back(1);
    wr(10'h155);
    chk("lat_n0_active", 128'(act_e), 128'(0));
    @(posedge clk); #1;
    chk("lat_n1_active", 128'(act_e), 128'(0));
    @(posedge clk); #1;
    chk("lat_n2_active", 128'(act_e), 128'(1));
    chk("lat_n2_tx", 128'(tx_e), 128'(1));
    chk("lat_n2_active_odd", 128'(act_o), 128'(1));
    wait_frames(1, 400);

    // T2: two words, one frame
    push_w(10'h003, 1'b1);
    push_w(10'h2AA, 1'b0);
    frame_q.push_back(2);
    wr(10'h003);
    repeat (3) @(posedge clk);
    wr(10'h2AA);
    wait_frames(2, 600);

    // T3: fill while the start sequence runs, then overflow
    @(posedge clk); #1;
    frame_q.push_back(8);
    for (int i = 0; i < 8; i++) begin
      push_w(t3w[i], t3p[i]);
      data  = t3w[i];
      valid = 1'b1;
      @(posedge clk); #1;
    end
    chk("t3_full", 128'(full_e), 128'(1));
    chk("t3_ready", 128'(ready_e), 128'(0));
    chk("t3_level", 128'(level_e), 128'(8));
    chk("t3_ovf_before", 128'(ovf_e), 128'(0));
    data = 10'h111;
    @(posedge clk); #1;
    chk("t3_ovf_set", 128'(ovf_e), 128'(1));
    chk("t3_level_drop", 128'(level_e), 128'(8));
    clear_overflow = 1'b1;
    @(posedge clk); #1;
    chk("t3_ovf_collide", 128'(ovf_e), 128'(1));
    valid = 1'b0;
    @(posedge clk); #1;
    clear_overflow = 1'b0;
    chk("t3_ovf_clear", 128'(ovf_e), 128'(0));
    wait_frames(3, 1500);

    // T4: reset in the middle of data bit 4 with words still queued
    wr(10'h155);
    wr(10'h3FF);
    wr(10'h000);
    c = 0;
    while (flen < 110 && c < 400) begin
      @(posedge clk);
      c++;
    end
    chk("t4_reach_data", 128'(flen >= 110), 128'(1));
    #3;
    reset_n = 1'b0;
    #1;
    chk("t4_tx", 128'(tx_e), 128'(0));
    chk("t4_active", 128'(act_e), 128'(0));
    chk("t4_level", 128'(level_e), 128'(0));
    chk("t4_tx_odd", 128'(tx_o), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("t4_empty", 128'(empty_e), 128'(1));
    push_w(10'h0F0, 1'b1);
    frame_q.push_back(1);
    wr(10'h0F0);
    wait_frames(4, 400);
    nfr = 4;

`ifdef COAX_TX_PARITY_INJECT_EN
    // T6: one-shot parity inversion
    @(posedge clk); #1;
    inject = 1'b1;
    @(posedge clk); #1;
    inject = 1'b0;
    push_w(10'h155, 1'b1);
    push_w(10'h155, 1'b0);
    frame_q.push_back(2);
    wr(10'h155);
    wr(10'h155);
    wait_frames(5, 600);
    nfr = 5;
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("frames_total", 128'(frames_done), 128'(nfr));
    chk("exp_drained", 128'(exp_q.size()), 128'(0));
    chk("frame_q_drained", 128'(frame_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
